// File: rtl/stream_frame_gate.sv
// -----------------------------------------------------------------------------
// stream_frame_gate
//
// Purpose:
//   Whole-frame admission gate for the sensor pixel stream in the
//   clk_sensor_pix_2x domain. A frame is admitted only if acquisition and
//   stream enable are both set at the moment frame-valid rises. Once admitted,
//   a frame always runs to completion. Frames that are dropped are dropped
//   whole. The gated stream is registered with one cycle of latency. The
//   geometry of every admitted frame is measured and compared with the
//   programmed size.
//
// Ports:
//   clk                  pixel 2x clock
//   reset                asynchronous, active-high reset
//   i_fval / i_lval      frame / line valid from the sync buffer
//   iv_pix_data          pixel word, valid when i_fval & i_lval
//   i_acquisition_start  level, acquisition armed
//   i_stream_enable      level, stream enabled
//   i_encrypt_state      1 = licence ok, 0 = blank the pixel data
//   iv_line_num          expected lines per frame
//   iv_word_per_line     expected words per line
//   o_fval / o_lval      gated frame / line valid (1 clk latency)
//   ov_pix_data          gated pixel word, zero outside active lines
//   ov_line_cnt          lines counted in the last completed frame
//   ov_word_cnt          words in the last line of the last completed frame
//   o_frame_done         1-cycle pulse at the end of each admitted frame
//   o_frame_err          1-cycle pulse with o_frame_done on geometry mismatch
// -----------------------------------------------------------------------------
module stream_frame_gate #(
    parameter int SENSOR_DAT_WIDTH = 10,
    parameter int CHANNEL_NUM      = 4,
    parameter int REG_WD           = 32
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  i_fval,
    input  logic                                  i_lval,
    input  logic [SENSOR_DAT_WIDTH*CHANNEL_NUM-1:0] iv_pix_data,
    input  logic                                  i_acquisition_start,
    input  logic                                  i_stream_enable,
    input  logic                                  i_encrypt_state,
    input  logic [REG_WD-1:0]                     iv_line_num,
    input  logic [REG_WD-1:0]                     iv_word_per_line,
    output logic                                  o_fval,
    output logic                                  o_lval,
    output logic [SENSOR_DAT_WIDTH*CHANNEL_NUM-1:0] ov_pix_data,
    output logic [REG_WD-1:0]                     ov_line_cnt,
    output logic [REG_WD-1:0]                     ov_word_cnt,
    output logic                                  o_frame_done,
    output logic                                  o_frame_err
);

    localparam int                DW      = SENSOR_DAT_WIDTH * CHANNEL_NUM;
    localparam logic [REG_WD-1:0] CNT_MAX = {REG_WD{1'b1}};
    localparam logic [REG_WD-1:0] CNT_ONE = {{(REG_WD-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              fval_d_q, fval_d_d;
    logic              lval_d_q, lval_d_d;
    logic [REG_WD-1:0] line_acc_q, line_acc_d;
    logic [REG_WD-1:0] word_acc_q, word_acc_d;
    logic              o_fval_q, o_fval_d;
    logic              o_lval_q, o_lval_d;
    logic [DW-1:0]     pix_q, pix_d;
    logic [REG_WD-1:0] line_cnt_q, line_cnt_d;
    logic [REG_WD-1:0] word_cnt_q, word_cnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic fval_rise_s;
    logic fval_fall_s;
    logic lval_rise_s;
    logic enable_s;
    logic admit_s;
    logic pass_s;

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [REG_WD-1:0] sat_inc(input logic [REG_WD-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    // Next-state logic: edge detect, admission FSM, gated stream, geometry counters.
    always_comb begin
        fval_rise_s = i_fval & ~fval_d_q;
        fval_fall_s = ~i_fval & fval_d_q;
        lval_rise_s = i_lval & ~lval_d_q;
        enable_s    = i_acquisition_start & i_stream_enable;
        // Enable is sampled only at the frame start, so frames are never split.
        admit_s     = (state_q == IDLE) & fval_rise_s & enable_s;
        pass_s      = admit_s | (state_q == ACTIVE);

        fval_d_d    = i_fval;
        lval_d_d    = i_lval;
        line_cnt_d  = line_cnt_q;
        word_cnt_d  = word_cnt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (admit_s) begin
                    state_d = ACTIVE;
                end else begin
                    state_d = IDLE;
                end
            end
            ACTIVE: begin
                if (fval_fall_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = ACTIVE;
                end
            end
            default: state_d = IDLE;
        endcase

        o_fval_d = pass_s & i_fval;
        o_lval_d = pass_s & i_fval & i_lval;
        // Data forced to zero outside active lines and when the licence is bad.
        if (o_lval_d & i_encrypt_state) begin
            pix_d = iv_pix_data;
        end else begin
            pix_d = {DW{1'b0}};
        end

        // A line starting on the admitting cycle is already line one.
        if (admit_s) begin
            line_acc_d = lval_rise_s ? CNT_ONE : {REG_WD{1'b0}};
        end else if ((state_q == ACTIVE) & i_fval & lval_rise_s) begin
            line_acc_d = sat_inc(line_acc_q);
        end else begin
            line_acc_d = line_acc_q;
        end

        // Clear-and-count on the first word of a line gives one.
        if (pass_s & i_fval & lval_rise_s) begin
            word_acc_d = CNT_ONE;
        end else if (pass_s & i_fval & i_lval) begin
            word_acc_d = sat_inc(word_acc_q);
        end else begin
            word_acc_d = word_acc_q;
        end

        if ((state_q == ACTIVE) & fval_fall_s) begin
            line_cnt_d = line_acc_q;
            word_cnt_d = word_acc_q;
            done_d     = 1'b1;
            err_d      = (line_acc_q != iv_line_num) | (word_acc_q != iv_word_per_line);
        end else begin
            done_d     = 1'b0;
            err_d      = 1'b0;
        end
    end

    // State and output registers; fval history preloaded high so a frame in
    // flight at reset release never produces a rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            fval_d_q   <= 1'b1;
            lval_d_q   <= 1'b0;
            line_acc_q <= {REG_WD{1'b0}};
            word_acc_q <= {REG_WD{1'b0}};
            o_fval_q   <= 1'b0;
            o_lval_q   <= 1'b0;
            pix_q      <= {DW{1'b0}};
            line_cnt_q <= {REG_WD{1'b0}};
            word_cnt_q <= {REG_WD{1'b0}};
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fval_d_q   <= fval_d_d;
            lval_d_q   <= lval_d_d;
            line_acc_q <= line_acc_d;
            word_acc_q <= word_acc_d;
            o_fval_q   <= o_fval_d;
            o_lval_q   <= o_lval_d;
            pix_q      <= pix_d;
            line_cnt_q <= line_cnt_d;
            word_cnt_q <= word_cnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign o_fval       = o_fval_q;
    assign o_lval       = o_lval_q;
    assign ov_pix_data  = pix_q;
    assign ov_line_cnt  = line_cnt_q;
    assign ov_word_cnt  = word_cnt_q;
    assign o_frame_done = done_q;
    assign o_frame_err  = err_q;

endmodule
